// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// The optional done mailbox is enabled with the DMEM_MMIO_EN macro.
package dmem_resp_pkg;

   localparam int WORD_W   = 32;
   localparam int MAX_WAIT = 15;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // The wait counter never needs fewer than one bit, even with zero wait states.
   function automatic int cnt_width(input int ws);
      return (ws < 1) ? 1 : $clog2(ws + 1);
   endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// Request/acknowledge bus between the processor data port and the responder.
// The done/done_code mailbox signals exist only when DMEM_MMIO_EN is defined.
interface dmem_wait_responder_if;

   logic                               req;
   logic                               we;
   logic [dmem_resp_pkg::WORD_W-1:0]   addr;
   logic [dmem_resp_pkg::WORD_W-1:0]   wdata;
   logic [dmem_resp_pkg::WORD_W-1:0]   rdata;
   logic                               ack;
   logic                               err;
   logic                               busy;
`ifdef DMEM_MMIO_EN
   logic                               done;
   logic [dmem_resp_pkg::WORD_W-1:0]   done_code;
`endif

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack, err, busy
`ifdef DMEM_MMIO_EN
      , input done, done_code
`endif
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack, err, busy
`ifdef DMEM_MMIO_EN
      , output done, done_code
`endif
   );

endinterface

// File: rtl/dmem_resp_ram.sv
// Word RAM for the responder: synchronous write, registered read with enable.
// Array contents are never cleared; only the read register resets.
module dmem_resp_ram
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [WORD_W-1:0]          wdata,
   input  logic                       re,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [WORD_W-1:0]          rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds its value between enabled reads so rdata stays stable across acks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder: req/ack handshake with programmable wait states and access checking.
// Define DMEM_MMIO_EN to add the sticky done mailbox at MMIO_ADDR.
module dmem_wait_responder
   import dmem_resp_pkg::*;
#(
   parameter int                DEPTH       = 64,
   parameter int                WAIT_STATES = 2,
   parameter logic [WORD_W-1:0] MMIO_ADDR   = 32'hFFFC
) (
   input  logic                  clk,
   input  logic                  reset,
   dmem_wait_responder_if.slave  bus
);

   localparam int                WS_EFF     = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
   localparam int                AW         = $clog2(DEPTH);
   localparam int                CW         = cnt_width(WS_EFF);
   localparam logic [WORD_W-1:0] BYTE_LIMIT = WORD_W'(4 * DEPTH);
   localparam logic [CW-1:0]     CNT_LOAD   = CW'(WS_EFF);

   state_t             state;
   state_t             next_state;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      next_cnt;
   logic               lat_we;
   logic [WORD_W-1:0]  lat_addr;
   logic [WORD_W-1:0]  lat_wdata;
   logic               cur_we;
   logic [WORD_W-1:0]  cur_addr;
   logic [WORD_W-1:0]  cur_wdata;
   logic               addr_mb;
   logic               cur_mmio;
   logic               cur_bad;
   logic               accept;
   logic               ram_we;
   logic               ram_re;
   logic [WORD_W-1:0]  ram_q;

   // In IDLE the live bus is decoded (the zero-wait path reads RAM on the accept edge);
   // afterwards only the latched copy matters, so bus changes mid-transaction are ignored.
   assign accept    = (state == IDLE) && bus.req;
   assign cur_we    = (state == IDLE) ? bus.we    : lat_we;
   assign cur_addr  = (state == IDLE) ? bus.addr  : lat_addr;
   assign cur_wdata = (state == IDLE) ? bus.wdata : lat_wdata;
   assign addr_mb   = (cur_addr == MMIO_ADDR);

`ifdef DMEM_MMIO_EN
   assign cur_mmio = addr_mb;
   assign cur_bad  = ((cur_addr[1:0] != 2'b00) || (cur_addr >= BYTE_LIMIT)) && !addr_mb;
`else
   assign cur_mmio = 1'b0;
   assign cur_bad  = (cur_addr[1:0] != 2'b00) || (cur_addr >= BYTE_LIMIT) || addr_mb;
`endif

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            if (bus.req) begin
               next_cnt   = CNT_LOAD;
               next_state = (WS_EFF > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            next_cnt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               next_state = RESP;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         if (accept) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
         end
      end
   end

   // Reads sample RAM on the edge entering RESP; writes commit on the edge leaving it.
   assign ram_re = (next_state == RESP) && !cur_we && !cur_bad && !cur_mmio;
   assign ram_we = (state == RESP) && cur_we && !cur_bad && !cur_mmio;

   dmem_resp_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .waddr (cur_addr[AW+1:2]),
      .wdata (cur_wdata),
      .re    (ram_re),
      .raddr (cur_addr[AW+1:2]),
      .rdata (ram_q)
   );

   assign bus.ack  = (state == RESP);
   assign bus.err  = (state == RESP) && cur_bad;
   assign bus.busy = (state != IDLE);

`ifdef DMEM_MMIO_EN
   logic               done_q;
   logic [WORD_W-1:0]  code_q;
   logic [WORD_W-1:0]  mmio_q;
   logic               rd_from_mmio;

   // Only the first mailbox write is recorded; a mailbox read snapshots the code like a RAM read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q       <= 1'b0;
         code_q       <= '0;
         mmio_q       <= '0;
         rd_from_mmio <= 1'b0;
      end else begin
         if ((state == RESP) && cur_we && cur_mmio && !done_q) begin
            done_q <= 1'b1;
            code_q <= cur_wdata;
         end
         if ((next_state == RESP) && !cur_we && cur_mmio) begin
            mmio_q       <= code_q;
            rd_from_mmio <= 1'b1;
         end else if (ram_re) begin
            rd_from_mmio <= 1'b0;
         end
      end
   end

   assign bus.done      = done_q;
   assign bus.done_code = code_q;
   assign bus.rdata     = rd_from_mmio ? mmio_q : ram_q;
`else
   assign bus.rdata = ram_q;
`endif

endmodule
